// File: rtl/dma_engine.sv
// dma_engine: block-copy engine that borrows the CPU's data-memory port, 1 byte/cycle
module dma_engine #(
    parameter int MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       start,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cpu_pause,
    input  logic [7:0] cpu_readaddr,
    input  logic       cpu_indir_read_en,
    input  logic [7:0] cpu_writeaddr,
    input  logic [7:0] cpu_writedata,
    input  logic       cpu_write_en,
    output logic [7:0] mem_readaddr,
    output logic       mem_indir_read_en,
    input  logic [7:0] mem_readdata,
    output logic [7:0] mem_writeaddr,
    output logic [7:0] mem_writedata,
    output logic       mem_write_en
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, YIELD} state_t;
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
    state_t     state_q, state_d;
    logic [7:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_left_q, rd_left_d;
    logic [7:0] burst_q, burst_d, saved_ra_q, saved_ra_d;
    logic       rd_valid_q, rd_valid_d, saved_ind_q, saved_ind_d;
    logic       done_q, done_d, err_q, err_d, wr_en;

    // next state, copy datapath and memory-port ownership mux
    always_comb begin
        state_d           = state_q;
        rd_ptr_d          = rd_ptr_q;
        wr_ptr_d          = wr_ptr_q;
        rd_left_d         = rd_left_q;
        burst_d           = burst_q;
        rd_valid_d        = rd_valid_q;
        saved_ra_d        = saved_ra_q;
        saved_ind_d       = saved_ind_q;
        done_d            = 1'b0;
        err_d             = 1'b0;
        mem_readaddr      = cpu_readaddr;
        mem_indir_read_en = cpu_indir_read_en;
        mem_writeaddr     = cpu_writeaddr;
        mem_writedata     = cpu_writedata;
        wr_en             = cpu_write_en;
        if (state_q == RUN || state_q == DRAIN) begin
            mem_writeaddr = wr_ptr_q;
            mem_writedata = mem_readdata;
            wr_en         = rd_valid_q;
            wr_ptr_d      = wr_ptr_q + {7'd0, rd_valid_q};
        end
        case (state_q)
            IDLE: if (start) begin
                saved_ra_d  = cpu_readaddr;
                saved_ind_d = cpu_indir_read_en;
                if (len == 8'd0) done_d = 1'b1;
                else if (dst < 8'h10 || {1'b0, dst} + {1'b0, len} > 9'h100) err_d = 1'b1;
                else begin
                    rd_ptr_d   = src;
                    wr_ptr_d   = dst;
                    rd_left_d  = len;
                    rd_valid_d = 1'b0;
                    burst_d    = 8'd0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                mem_readaddr      = rd_ptr_q;
                mem_indir_read_en = 1'b0;
                rd_ptr_d          = rd_ptr_q + 8'd1;
                rd_left_d         = rd_left_q - 8'd1;
                burst_d           = burst_q + 8'd1;
                rd_valid_d        = 1'b1;
                state_d           = (rd_left_d == 8'd0 || burst_d == BURST_MAX) ? DRAIN : RUN;
            end
            DRAIN: begin
                mem_readaddr      = saved_ra_q;
                mem_indir_read_en = saved_ind_q;
                rd_valid_d        = 1'b0;
                done_d            = rd_left_q == 8'd0;
                state_d           = (rd_left_q == 8'd0) ? IDLE : YIELD;
            end
            YIELD: begin
                saved_ra_d  = cpu_readaddr;
                saved_ind_d = cpu_indir_read_en;
                burst_d     = 8'd0;
                state_d     = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_write_en = wr_en & ~pause;
    assign busy         = state_q != IDLE;
    assign cpu_pause    = state_q == RUN || state_q == DRAIN;
    assign done         = done_q;
    assign err          = err_q;

    // state register; system pause freezes everything and drops the pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= 8'd0;
            wr_ptr_q    <= 8'd0;
            rd_left_q   <= 8'd0;
            burst_q     <= 8'd0;
            rd_valid_q  <= 1'b0;
            saved_ra_q  <= 8'd0;
            saved_ind_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (pause) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_left_q   <= rd_left_d;
            burst_q     <= burst_d;
            rd_valid_q  <= rd_valid_d;
            saved_ra_q  <= saved_ra_d;
            saved_ind_q <= saved_ind_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
endmodule
